// File: rtl/regfile_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_arb_pkg: shared widths, FSM encoding and client ids. Rev 1.0
// ---------------------------------------------------------------------------
package regfile_arb_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int AW_DEFAULT = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2: combinational 2-way round-robin select. Rev 1.0
// ---------------------------------------------------------------------------
module rr_arb2
    import regfile_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic winner,
    output logic any_req
);

    always_comb begin
        any_req = req0 | req1;
        winner  = CLIENT0;
        // A tie goes to whichever client the pointer currently favours.
        if (req0 && req1) begin
            winner = prio;
        end else if (req1) begin
            winner = CLIENT1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_arbiter: two-client round-robin access to a single-port register file. Rev 1.0
// ---------------------------------------------------------------------------
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          rf_write,
    output logic [AW-1:0] rf_writenum,
    output logic [AW-1:0] rf_readnum,
    output logic [DW-1:0] rf_data_in,
    input  logic [DW-1:0] rf_data_out
);

    state_t        state;
    state_t        state_next;
    logic          prio;
    logic          winner;
    logic          any_req;
    logic          accept;
    logic          issue;
    logic          cmd_id;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    rr_arb2 u_rr_arb2 (
        .req0    (req0),
        .req1    (req1),
        .prio    (prio),
        .winner  (winner),
        .any_req (any_req)
    );

    assign issue  = (state == ISSUE);
    assign accept = (state == IDLE) && any_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command register: the latched access drives the register file during ISSUE
    // and keeps the rf address/data outputs stable afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio      <= CLIENT0;
            cmd_id    <= CLIENT0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (accept) begin
            prio      <= ~winner;
            cmd_id    <= winner;
            cmd_we    <= (winner == CLIENT1) ? we1    : we0;
            cmd_addr  <= (winner == CLIENT1) ? addr1  : addr0;
            cmd_wdata <= (winner == CLIENT1) ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata   <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= issue && !cmd_we && (cmd_id == CLIENT0);
            rvalid1 <= issue && !cmd_we && (cmd_id == CLIENT1);
            if (issue && !cmd_we) begin
                rdata <= rf_data_out;
            end
        end
    end

    assign gnt0        = issue && (cmd_id == CLIENT0);
    assign gnt1        = issue && (cmd_id == CLIENT1);
    assign rf_write    = issue && cmd_we;
    assign rf_writenum = cmd_addr;
    assign rf_readnum  = cmd_addr;
    assign rf_data_in  = cmd_wdata;

endmodule
`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile_arbiter: directed scenarios plus randomized two-client traffic
// checked against a register-level reference model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_regfile_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int N_OPS = 40;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0    = 1'b0;
    logic          req1    = 1'b0;
    logic          we0     = 1'b0;
    logic          we1     = 1'b0;
    logic [AW-1:0] addr0   = '0;
    logic [AW-1:0] addr1   = '0;
    logic [DW-1:0] wdata0  = '0;
    logic [DW-1:0] wdata1  = '0;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic          rf_write;
    logic [AW-1:0] rf_writenum;
    logic [AW-1:0] rf_readnum;
    logic [DW-1:0] rf_data_in;
    logic [DW-1:0] rf_data_out;

    // Register file attached to the arbiter; rf_load lets the bench preset it.
    logic [DW-1:0] rf        [8];
    logic [DW-1:0] rf_preset [8];
    logic          rf_load = 1'b0;

    logic [DW-1:0] ref_mem [8];
    logic          op_we   [2];
    logic [AW-1:0] op_addr [2];
    logic [DW-1:0] op_wd   [2];
    bit            drv_done [2];
    int            dut_gcnt [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req0        (req0),
        .req1        (req1),
        .we0         (we0),
        .we1         (we1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .rvalid0     (rvalid0),
        .rvalid1     (rvalid1),
        .rdata       (rdata),
        .rf_write    (rf_write),
        .rf_writenum (rf_writenum),
        .rf_readnum  (rf_readnum),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out)
    );

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 8; i++) rf[i] <= rf_preset[i];
        end else if (rf_write) begin
            rf[rf_writenum] <= rf_data_in;
        end
    end
    assign rf_data_out = rf[rf_readnum];

    task automatic set_client(input int c, input logic r, input logic w,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (c == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    function automatic logic gnt_of(input int c);
        return (c == 0) ? gnt0 : gnt1;
    endfunction

    function automatic logic rvalid_of(input int c);
        return (c == 0) ? rvalid0 : rvalid1;
    endfunction

    task automatic wait_gnt(input int c, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (gnt_of(c)) got = 1'b1;
        end
    endtask

    // Full client handshake; returns at the negedge of the cycle after ISSUE.
    task automatic access(input int c, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output bit ok, output logic [DW-1:0] rd);
        bit got;
        set_client(c, 1'b1, w, a, d);
        wait_gnt(c, 8, got);
        @(posedge clk); #1;
        set_client(c, 1'b0, w, a, d);
        @(negedge clk);
        rd = rdata;
        ok = got && (w ? !rvalid_of(c) : rvalid_of(c));
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) rf_preset[i] = '0;
        rf_load = 1'b1;
        repeat (3) @(negedge clk);
        rf_load = 1'b0;
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, rf_write} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: gnt0,gnt1,rvalid0,rvalid1,rf_write=%b expected 00000",
                     {gnt0, gnt1, rvalid0, rvalid1, rf_write});
        end
        checks++;
        if (rdata !== '0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0000", rdata);
        end
        checks++;
        if ({rf_writenum, rf_readnum} !== '0) begin
            errors++; $display("FAIL reset_rfnum: got %0d/%0d expected 0/0", rf_writenum, rf_readnum);
        end
        checks++;
        if (rf_data_in !== '0) begin
            errors++; $display("FAIL reset_rf_data_in: got %h expected 0000", rf_data_in);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_write();
        set_client(0, 1'b1, 1'b1, 3'd3, 16'h1234);
        @(negedge clk);
        checks++;
        if ({gnt1, gnt0} !== 2'b01) begin
            errors++; $display("FAIL write_gnt: gnt1,gnt0=%b%b expected 01", gnt1, gnt0);
        end
        checks++;
        if ({rf_write, rf_writenum, rf_data_in} !== {1'b1, 3'd3, 16'h1234}) begin
            errors++;
            $display("FAIL write_rf: rf_write=%b num=%0d data=%h expected 1 3 1234",
                     rf_write, rf_writenum, rf_data_in);
        end
        @(posedge clk); #1;
        set_client(0, 1'b0, 1'b1, 3'd3, 16'h1234);
        @(negedge clk);
        checks++;
        if ({gnt0, rf_write, rvalid0, rvalid1} !== 4'b0) begin
            errors++;
            $display("FAIL write_after: gnt0,rf_write,rvalid0,rvalid1=%b expected 0000",
                     {gnt0, rf_write, rvalid0, rvalid1});
        end
        checks++;
        if (rf[3] !== 16'h1234) begin
            errors++; $display("FAIL write_r3: R3=%h expected 1234", rf[3]);
        end
    endtask

    task automatic test_read();
        set_client(1, 1'b1, 1'b0, 3'd3, 16'h0000);
        @(negedge clk);
        checks++;
        if ({gnt1, gnt0, rf_write, rf_readnum} !== {1'b1, 1'b0, 1'b0, 3'd3}) begin
            errors++;
            $display("FAIL read_issue: gnt1=%b gnt0=%b rf_write=%b readnum=%0d expected 1 0 0 3",
                     gnt1, gnt0, rf_write, rf_readnum);
        end
        @(posedge clk); #1;
        set_client(1, 1'b0, 1'b0, 3'd3, 16'h0000);
        @(negedge clk);
        checks++;
        if ({rvalid1, rvalid0, rdata} !== {1'b1, 1'b0, 16'h1234}) begin
            errors++;
            $display("FAIL read_data: rvalid1=%b rvalid0=%b rdata=%h expected 1 0 1234",
                     rvalid1, rvalid0, rdata);
        end
        @(negedge clk);
        checks++;
        if ({rvalid1, rdata} !== {1'b0, 16'h1234}) begin
            errors++; $display("FAIL read_hold: rvalid1=%b rdata=%h expected 0 1234", rvalid1, rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g;
        set_client(0, 1'b1, 1'b1, 3'd1, 16'hAAAA);
        set_client(1, 1'b1, 1'b1, 3'd1, 16'h5555);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k % 2 == 1)            exp_g = 2'b00;
            else if ((k / 2) % 2 == 0) exp_g = 2'b01;
            else                       exp_g = 2'b10;
            checks++;
            if ({gnt1, gnt0} !== exp_g) begin
                errors++; $display("FAIL b2b_grant[%0d]: gnt1,gnt0=%b%b expected %b", k, gnt1, gnt0, exp_g);
            end
        end
        set_client(0, 1'b0, 1'b1, 3'd1, 16'hAAAA);
        set_client(1, 1'b0, 1'b1, 3'd1, 16'h5555);
        @(negedge clk);
        checks++;
        if ({gnt1, gnt0, rf[1]} !== {2'b00, 16'hAAAA}) begin
            errors++; $display("FAIL b2b_end: gnt1,gnt0=%b%b R1=%h expected 00 AAAA", gnt1, gnt0, rf[1]);
        end
    endtask

    task automatic test_priority();
        bit            ok;
        logic [DW-1:0] rd;
        int            first;
        logic [1:0]    exp_g;
        for (int i = 0; i < 2; i++) begin
            first = (i == 0) ? 1 : 0;
            exp_g = (first == 1) ? 2'b01 : 2'b10;
            access(first, 1'b0, 3'd2, 16'h0000, ok, rd);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL prio_solo[%0d]: handshake ok=%b expected 1", i, ok);
            end
            set_client(0, 1'b1, 1'b0, 3'd4, 16'h0000);
            set_client(1, 1'b1, 1'b0, 3'd4, 16'h0000);
            @(negedge clk);
            checks++;
            if ({gnt1, gnt0} !== exp_g) begin
                errors++; $display("FAIL prio_tie[%0d]: gnt1,gnt0=%b%b expected %b", i, gnt1, gnt0, exp_g);
            end
            @(posedge clk); #1;
            set_client(0, 1'b0, 1'b0, 3'd4, 16'h0000);
            set_client(1, 1'b0, 1'b0, 3'd4, 16'h0000);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_during_issue();
        bit got;
        set_client(0, 1'b1, 1'b1, 3'd5, 16'hBEEF);
        wait_gnt(0, 8, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL rst_issue_gnt: got grant=%b expected 1", got);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({gnt0, rf_write, rf_writenum, rf_data_in} !== '0) begin
            errors++;
            $display("FAIL rst_issue_clear: gnt0=%b rf_write=%b num=%0d data=%h expected all 0",
                     gnt0, rf_write, rf_writenum, rf_data_in);
        end
        @(negedge clk);
        checks++;
        if (rf[5] !== 16'h0000) begin
            errors++; $display("FAIL rst_issue_r5: R5=%h expected 0000", rf[5]);
        end
        reset_n = 1'b1;
        wait_gnt(0, 8, got);
        checks++;
        if (!got || rf_writenum !== 3'd5) begin
            errors++; $display("FAIL rst_reissue: grant=%b num=%0d expected 1 5", got, rf_writenum);
        end
        @(posedge clk); #1;
        set_client(0, 1'b0, 1'b1, 3'd5, 16'hBEEF);
        @(negedge clk);
        checks++;
        if (rf[5] !== 16'hBEEF) begin
            errors++; $display("FAIL rst_reissue_r5: R5=%h expected BEEF", rf[5]);
        end
    endtask

    task automatic drive_client(input int c);
        bit got;
        for (int n = 0; n < N_OPS; n++) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            op_we[c]   = 1'($urandom_range(0, 1));
            op_addr[c] = AW'($urandom_range(0, 7));
            op_wd[c]   = DW'($urandom);
            set_client(c, 1'b1, op_we[c], op_addr[c], op_wd[c]);
            wait_gnt(c, 20, got);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL rand_timeout: client %0d op %0d no grant in 20 cycles, expected one", c, n);
                set_client(c, 1'b0, op_we[c], op_addr[c], op_wd[c]);
                break;
            end
            @(posedge clk); #1;
            set_client(c, 1'b0, op_we[c], op_addr[c], op_wd[c]);
        end
        drv_done[c] = 1'b1;
    endtask

    // Reference: an idle arbiter takes the sole requester, or on a tie the client
    // not served last; one access occupies two cycles; reads see all prior writes.
    task automatic monitor();
        bit            s_req [2];
        bit            eg    [2];
        bit            exp_rv[2];
        bit            nxt_rv[2];
        logic [DW-1:0] exp_rd[2];
        bit            prev_issue;
        int            last;
        int            extra;
        int            cyc;
        s_req[0] = req0; s_req[1] = req1;
        exp_rv = '{1'b0, 1'b0};
        prev_issue = 1'b0;
        last  = 1;
        extra = 0;
        cyc   = 0;
        while (extra < 4 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (drv_done[0] && drv_done[1]) extra++;
            eg = '{1'b0, 1'b0};
            if (!prev_issue && (s_req[0] || s_req[1])) begin
                if (s_req[0] && s_req[1]) eg[1 - last] = 1'b1;
                else if (s_req[0])        eg[0] = 1'b1;
                else                      eg[1] = 1'b1;
            end
            dut_gcnt[0] += int'(gnt0);
            dut_gcnt[1] += int'(gnt1);
            checks++;
            if ({gnt1, gnt0} !== {eg[1], eg[0]}) begin
                errors++;
                $display("FAIL rand_grant: cycle %0d gnt1,gnt0=%b%b expected %b%b", cyc, gnt1, gnt0, eg[1], eg[0]);
            end
            checks++;
            if ({rvalid1, rvalid0} !== {exp_rv[1], exp_rv[0]}) begin
                errors++;
                $display("FAIL rand_rvalid: cycle %0d rvalid1,rvalid0=%b%b expected %b%b",
                         cyc, rvalid1, rvalid0, exp_rv[1], exp_rv[0]);
            end
            for (int c = 0; c < 2; c++) begin
                if (exp_rv[c]) begin
                    checks++;
                    if (rdata !== exp_rd[c]) begin
                        errors++;
                        $display("FAIL rand_rdata: cycle %0d client %0d rdata=%h expected %h", cyc, c, rdata, exp_rd[c]);
                    end
                end
            end
            nxt_rv = '{1'b0, 1'b0};
            for (int c = 0; c < 2; c++) begin
                if (eg[c]) begin
                    last = c;
                    if (op_we[c]) begin
                        ref_mem[op_addr[c]] = op_wd[c];
                    end else begin
                        nxt_rv[c] = 1'b1;
                        exp_rd[c] = ref_mem[op_addr[c]];
                    end
                end
            end
            exp_rv     = nxt_rv;
            prev_issue = eg[0] || eg[1];
            s_req[0]   = req0;
            s_req[1]   = req1;
        end
        checks++;
        if (cyc >= 4000) begin
            errors++; $display("FAIL rand_budget: ran %0d cycles, expected fewer than 4000", cyc);
        end
    endtask

    task automatic test_random();
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rf_preset[i] = DW'($urandom);
            ref_mem[i]   = rf_preset[i];
        end
        rf_load = 1'b1;
        @(negedge clk);
        rf_load = 1'b0;
        @(negedge clk);
        drv_done    = '{1'b0, 1'b0};
        dut_gcnt    = '{0, 0};
        reset_n = 1'b1;
        fork
            drive_client(0);
            drive_client(1);
            monitor();
        join
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (dut_gcnt[c] != N_OPS) begin
                errors++; $display("FAIL rand_gcount: client %0d grants=%0d expected %0d", c, dut_gcnt[c], N_OPS);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_priority();
        test_reset_during_issue();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter: DW, 16, data width of register file and client data.
REQ-002 Parameter: AW, 3, register address width (8 registers).
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Ports: req0/req1  input  1  client access request, held high until grant seen.
REQ-006 Ports: we0/we1  input  1  client op: 1 = write, 0 = read.
REQ-007 Ports: addr0/addr1  input  AW  client register number.
REQ-008 Ports: wdata0/wdata1  input  DW  client write data.
REQ-009 Ports: gnt0/gnt1  output  1  one-cycle grant pulse, marks the issue cycle.
REQ-010 Ports: rvalid0/rvalid1  output  1  one-cycle read-data-valid pulse.
REQ-011 Port: rdata  output  DW  registered read data, shared by both clients, qualified by rvalidN.
REQ-012 Ports: rf_write  output  1; rf_writenum, rf_readnum  output  AW; rf_data_in  output  DW; all drive the register file.
REQ-013 Port: rf_data_out  input  DW  combinational read data returned by the register file.

Function
REQ-014 FSM states: IDLE, ISSUE; IDLE -> ISSUE when req0|req1 is sampled high; ISSUE -> IDLE unconditionally.
REQ-015 In IDLE with requests pending, arbiter latches winner's id, we, addr and wdata into a command register at the clock edge.
REQ-016 Winner: single requester wins; if both request, the client equal to the priority pointer prio wins.
REQ-017 prio updates at the edge entering ISSUE to the non-winning client (round-robin); no client waits more than one other access.
REQ-018 In ISSUE: gntN = 1 for the latched client only; rf_write = latched we; rf_writenum = rf_readnum = latched addr; rf_data_in = latched wdata.
REQ-019 Outside ISSUE: rf_write = 0 and gnt0 = gnt1 = 0; rf_writenum, rf_readnum and rf_data_in hold the last latched values.
REQ-020 Read: at the edge ending ISSUE, rdata captures rf_data_out; rvalidN = 1 for exactly the following cycle; latency req-sample -> rvalid = 2 cycles.
REQ-021 Write: register file updates at the edge ending ISSUE; no rvalid pulse is generated; rdata holds its previous value.
REQ-022 Handshake: client keeps req, we, addr, wdata stable until it samples gntN high, then deasserts req in the following cycle; because IDLE always follows ISSUE, no access is issued twice.
REQ-023 Throughput: at most one access per 2 cycles; back-to-back requests from both clients alternate 0,1,0,1 when prio starts at 0.
REQ-024 Ordering: a read issued after a write to the same register returns the new value.
REQ-025 Requests arriving during ISSUE are only considered in the next IDLE cycle.

Reset
REQ-026 While reset_n = 0: state = IDLE, prio = 0, gnt0/gnt1/rvalid0/rvalid1/rf_write = 0, rdata = 0, rf_writenum = rf_readnum = 0, rf_data_in = 0.
REQ-027 Reset asserted during ISSUE aborts the access without a register-file write taking effect at the next edge; clients keep req and the access is reissued after reset release.
REQ-028 The first edge with reset_n = 1 behaves as an IDLE sample.

Structure
REQ-029 Shared package regfile_arb_pkg holds DW/AW defaults, the FSM state encoding (IDLE = 0, ISSUE = 1) and client id constants.
REQ-030 One sub-module rr_arb2: a 2-way round-robin select (inputs req0, req1, prio; outputs winner id, any_req); all sequential logic stays in regfile_arbiter.

Verification
REQ-031 Reset, then client 0 writes 0x1234 to R3 -> gnt0 pulses in cycle 2; rf_write = 1, rf_writenum = 3 in that cycle; rvalid0 stays 0.
REQ-032 Client 1 then reads R3 -> gnt1 in ISSUE; rvalid1 one cycle later with rdata = 0x1234.
REQ-033 Both clients hold req continuously (writes of 0xAAAA/0x5555 to R1) -> grants alternate gnt0, gnt1, gnt0, and each grant is 2 cycles apart.
REQ-034 Simultaneous requests after client 1 was granted last -> client 0 wins; after client 0 -> client 1 wins.
REQ-035 reset_n pulsed low during ISSUE of a write of 0xBEEF to R5 -> outputs clear immediately, R5 unchanged; after release the held req is reissued and R5 = 0xBEEF.
REQ-036 Random req/we/addr/wdata with a reference register model -> every rvalid rdata matches the model, and there are no lost or duplicate grants.
